acs_unit: RTL and testbench
===========================

ACS_UNIT -- requirements
Module: acs_unit

Interface
- REQ-001 The block SHALL have parameter PM_W, default 8: path-metric width in bits; legal range 7 to 12.
- REQ-002 The block SHALL have parameter NORM_T, default 64: normalization threshold; it SHALL be less than 2^(PM_W-1).
- REQ-003 The block SHALL have parameter INIT_PM, default 16: reset metric of states 1 to 3.
- REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge triggered.
- REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-006 The block SHALL have port clear, input, 1 bit: synchronous restart of the trellis.
- REQ-007 The block SHALL have port valid_in, input, 1 bit: branch metrics are valid this cycle.
- REQ-008 The block SHALL have ports bm00, bm01, bm10 and bm11, each input, 2 bits: Hamming distance of the received pair to codewords 00, 01, 10 and 11 (range 0 to 2).
- REQ-009 The block SHALL have port valid_out, input/output direction output, 1 bit: decisions and metrics are updated.
- REQ-010 The block SHALL have port dec, output, 4 bits: survivor decision bit per next-state (bit index = state).
- REQ-011 The block SHALL have ports pm0, pm1, pm2 and pm3, each output, PM_W bits: registered path metrics.
- REQ-012 The block SHALL have port best_state, output, 2 bits: index of the lowest registered path metric.

Function
- REQ-013 The trellis SHALL use K=3 with generators (7,5); state s={s1,s0}={u(t-1),u(t-2)}; next state ns={u,s1}.
- REQ-014 The branch codeword from state s with input u SHALL be c1=u^s1^s0 and c0=u^s0.
- REQ-015 Predecessors of ns={u,a} SHALL be p0={a,0} and p1={a,1}. Candidate metrics:
  - ns0: pm0+bm00 vs pm1+bm11
  - ns1: pm2+bm10 vs pm3+bm01
  - ns2: pm0+bm11 vs pm1+bm00
  - ns3: pm2+bm01 vs pm3+bm10
- REQ-016 For each ns, the block SHALL select the smaller candidate and set dec[ns]=0 when p0 wins and 1 when p1 wins.
- REQ-017 On a tie, the block SHALL select p0 (dec=0).
- REQ-018 Adds and compares SHALL use PM_W+1 bits internally; a selected sum exceeding 2^PM_W-1 SHALL saturate to 2^PM_W-1.
- REQ-019 Normalization: if all four selected metrics are >= NORM_T, the block SHALL subtract NORM_T from each before registering; otherwise it SHALL register them unchanged.
- REQ-020 Latency: on a cycle with valid_in=1, pm0-pm3, dec and best_state SHALL update at the next rising edge, and valid_out SHALL be 1 for exactly that following cycle.
- REQ-021 When valid_in=0, pm0-pm3, dec and best_state SHALL hold, and valid_out SHALL be 0 next cycle.
- REQ-022 best_state SHALL be computed from the metrics being registered, lowest index winning ties; it is registered with them.
- REQ-023 Back-to-back valid_in every cycle SHALL be sustained with no bubbles; there is no backpressure.
- REQ-024 clear=1 SHALL load the reset values synchronously at the next edge and SHALL take priority over valid_in (that cycle's metrics are discarded); valid_out SHALL be 0 next cycle.

Reset
- REQ-025 While rst_n=0, the block SHALL immediately force pm0=0, pm1=pm2=pm3=INIT_PM, dec=0, best_state=0 and valid_out=0.
- REQ-026 Reset asserted mid-stream SHALL abandon the in-flight update; the first valid_in after rst_n rises SHALL be processed from the reset metrics.

Verification
- REQ-027 Reset, then one valid_in with bm={00:0,01:1,10:1,11:2} -> pm={0,17,2,17}, dec=0000, best_state=0, valid_out pulse of 1 cycle.
- REQ-028 Reset, then valid_in with bm={00:2,01:1,10:1,11:0} -> pm={2,17,0,17}, dec=0000, best_state=2.
- REQ-029 Force all metrics >= 64 (e.g. with INIT_PM=100 for all but state 0 and a long noisy stream, or with directed pm via 60 cycles of bm all 2) -> at the crossing update each pm is reduced by exactly 64, with relative differences preserved.
- REQ-030 Encoded all-zero stream with bm00=0 and the others nonzero for 10 cycles, with one 2-cycle valid_in gap -> pm0 stays 0, best_state=0 throughout, and outputs hold during the gap.
- REQ-031 Assert clear and valid_in in the same cycle -> next cycle pm={0,16,16,16} and valid_out=0.
- REQ-032 Drop rst_n asynchronously between edges mid-stream -> outputs reach reset values before the next edge.

Source files
------------

// File: rtl/acs_unit.sv
// acs_unit: add-compare-select stage for the K=3, (7,5) Viterbi trellis.
// Four path metrics are updated per valid branch-metric set. Each update
// produces one survivor decision bit per next-state. Metrics saturate at the
// top of their range and are renormalised once all four reach NORM_T.
module acs_unit #(
  parameter int PM_W    = 8,
  parameter int NORM_T  = 64,
  parameter int INIT_PM = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            valid_in,
  input  logic [1:0]      bm00,
  input  logic [1:0]      bm01,
  input  logic [1:0]      bm10,
  input  logic [1:0]      bm11,
  output logic            valid_out,
  output logic [3:0]      dec,
  output logic [PM_W-1:0] pm0,
  output logic [PM_W-1:0] pm1,
  output logic [PM_W-1:0] pm2,
  output logic [PM_W-1:0] pm3,
  output logic [1:0]      best_state
);

  localparam logic [PM_W:0]   PM_MAX = {1'b0, {PM_W{1'b1}}};
  localparam logic [PM_W-1:0] NORM_V = PM_W'(NORM_T);
  localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);
  localparam logic [PM_W-1:0] ZERO_V = {PM_W{1'b0}};

  // Widen a metric by one bit and add a branch metric, so the sum cannot wrap.
  function automatic logic [PM_W:0] add_bm(input logic [PM_W-1:0] pm, input logic [1:0] bm);
    return {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
  endfunction

  // Clamp a widened sum back into the PM_W-bit metric range.
  function automatic logic [PM_W-1:0] sat(input logic [PM_W:0] x);
    logic [PM_W-1:0] r;
    if (x > PM_MAX) begin
      r = {PM_W{1'b1}};
    end else begin
      r = x[PM_W-1:0];
    end
    return r;
  endfunction

  logic [PM_W-1:0] pm_r    [4];
  logic [PM_W:0]   cand0_s [4];
  logic [PM_W:0]   cand1_s [4];
  logic [PM_W-1:0] sel_s   [4];
  logic [PM_W-1:0] nxt_s   [4];
  logic [3:0]      dec_s;
  logic            norm_s;
  logic [1:0]      best_s;

  // Candidate metrics: ns={u,a} is reached from p0={a,0} and p1={a,1}.
  always_comb begin
    cand0_s[0] = add_bm(pm_r[0], bm00);
    cand1_s[0] = add_bm(pm_r[1], bm11);
    cand0_s[1] = add_bm(pm_r[2], bm10);
    cand1_s[1] = add_bm(pm_r[3], bm01);
    cand0_s[2] = add_bm(pm_r[0], bm11);
    cand1_s[2] = add_bm(pm_r[1], bm00);
    cand0_s[3] = add_bm(pm_r[2], bm01);
    cand1_s[3] = add_bm(pm_r[3], bm10);
  end

  // Compare-select on the full-width sums; ties keep p0. Also flag renormalisation.
  always_comb begin
    dec_s  = 4'b0000;
    norm_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel_s[i] = ZERO_V;
      if (cand1_s[i] < cand0_s[i]) begin
        dec_s[i] = 1'b1;
        sel_s[i] = sat(cand1_s[i]);
      end else begin
        dec_s[i] = 1'b0;
        sel_s[i] = sat(cand0_s[i]);
      end
      if (sel_s[i] < NORM_V) begin
        norm_s = 1'b0;
      end else begin
        norm_s = norm_s;
      end
    end
  end

  // Renormalise when every metric has reached NORM_T, then pick the lowest (first index on ties).
  always_comb begin
    best_s = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (norm_s) begin
        nxt_s[i] = sel_s[i] - NORM_V;
      end else begin
        nxt_s[i] = sel_s[i];
      end
    end
    for (int i = 1; i < 4; i++) begin
      if (nxt_s[i] < nxt_s[best_s]) begin
        best_s = 2'(i);
      end else begin
        best_s = best_s;
      end
    end
  end

  // Metric, decision and best-state registers; clear restarts the trellis ahead of valid_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_r[0]    <= ZERO_V;
      pm_r[1]    <= INIT_V;
      pm_r[2]    <= INIT_V;
      pm_r[3]    <= INIT_V;
      dec        <= 4'b0000;
      best_state <= 2'd0;
      valid_out  <= 1'b0;
    end else if (clear) begin
      pm_r[0]    <= ZERO_V;
      pm_r[1]    <= INIT_V;
      pm_r[2]    <= INIT_V;
      pm_r[3]    <= INIT_V;
      dec        <= 4'b0000;
      best_state <= 2'd0;
      valid_out  <= 1'b0;
    end else if (valid_in) begin
      pm_r[0]    <= nxt_s[0];
      pm_r[1]    <= nxt_s[1];
      pm_r[2]    <= nxt_s[2];
      pm_r[3]    <= nxt_s[3];
      dec        <= dec_s;
      best_state <= best_s;
      valid_out  <= 1'b1;
    end else begin
      valid_out  <= 1'b0;
    end
  end

  assign pm0 = pm_r[0];
  assign pm1 = pm_r[1];
  assign pm2 = pm_r[2];
  assign pm3 = pm_r[3];

endmodule

// File: tb/tb_acs_unit.sv
// tb_acs_unit: scoreboard bench for acs_unit. The reference model walks the
// (7,5) trellis from its definition: codewords from state bits, then min-select,
// saturation and renormalisation on plain integers.
module tb_acs_unit;

  localparam int PM_W    = 8;
  localparam int NORM_T  = 64;
  localparam int INIT_PM = 16;
  localparam int MAXV    = (1 << PM_W) - 1;

  logic            clk = 1'b0;
  logic            rst_n, clear, valid_in;
  logic [1:0]      bm00, bm01, bm10, bm11;
  logic            valid_out;
  logic [3:0]      dec;
  logic [PM_W-1:0] pm0, pm1, pm2, pm3;
  logic [1:0]      best_state;

  always #5 clk = ~clk;

  acs_unit #(.PM_W(PM_W), .NORM_T(NORM_T), .INIT_PM(INIT_PM)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in),
    .bm00(bm00), .bm01(bm01), .bm10(bm10), .bm11(bm11),
    .valid_out(valid_out), .dec(dec),
    .pm0(pm0), .pm1(pm1), .pm2(pm2), .pm3(pm3),
    .best_state(best_state)
  );

  typedef struct packed {
    logic [7:0] p0, p1, p2, p3;
    logic [3:0] d;
    logic [1:0] b;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   mpm [4];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    mpm[0] = 0; mpm[1] = INIT_PM; mpm[2] = INIT_PM; mpm[3] = INIT_PM;
    cur.p0 = 8'd0; cur.p1 = 8'(INIT_PM); cur.p2 = 8'(INIT_PM); cur.p3 = 8'(INIT_PM);
    cur.d = 4'd0; cur.b = 2'd0;
    q.delete();
  endfunction

  // One trellis step: ns={u,a}, predecessors {a,b}, codeword c1=u^a^b, c0=u^b.
  function automatic void model_step(input int b00, input int b01, input int b10, input int b11);
    int bm [4];
    int np [4];
    int cand [2];
    int d, best, u, a, p;
    bit allhi;
    bm[0] = b00; bm[1] = b01; bm[2] = b10; bm[3] = b11;
    d = 0; allhi = 1'b1;
    for (int ns = 0; ns < 4; ns++) begin
      u = ns / 2; a = ns % 2;
      for (int b = 0; b < 2; b++) begin
        p = a * 2 + b;
        cand[b] = mpm[p] + bm[((u ^ a ^ b) * 2) + (u ^ b)];
      end
      if (cand[1] < cand[0]) begin np[ns] = cand[1]; d += (1 << ns); end
      else np[ns] = cand[0];
      if (np[ns] > MAXV) np[ns] = MAXV;
      if (np[ns] < NORM_T) allhi = 1'b0;
    end
    if (allhi) for (int i = 0; i < 4; i++) np[i] -= NORM_T;
    best = 0;
    for (int i = 1; i < 4; i++) if (np[i] < np[best]) best = i;
    for (int i = 0; i < 4; i++) mpm[i] = np[i];
    cur.p0 = 8'(np[0]); cur.p1 = 8'(np[1]); cur.p2 = 8'(np[2]); cur.p3 = 8'(np[3]);
    cur.d = 4'(d); cur.b = 2'(best);
    q.push_back(cur);
  endfunction

  // Monitor: pops an expectation whenever one is due, otherwise checks the outputs hold.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("valid_out pulse", int'(valid_out), 1);
      cmp("pm0", int'(pm0), int'(e.p0));
      cmp("pm1", int'(pm1), int'(e.p1));
      cmp("pm2", int'(pm2), int'(e.p2));
      cmp("pm3", int'(pm3), int'(e.p3));
      cmp("dec", int'(dec), int'(e.d));
      cmp("best_state", int'(best_state), int'(e.b));
    end else begin
      cmp("valid_out idle", int'(valid_out), 0);
      cmp("pm0 hold", int'(pm0), int'(cur.p0));
      cmp("pm1 hold", int'(pm1), int'(cur.p1));
      cmp("pm2 hold", int'(pm2), int'(cur.p2));
      cmp("pm3 hold", int'(pm3), int'(cur.p3));
      cmp("dec hold", int'(dec), int'(cur.d));
      cmp("best hold", int'(best_state), int'(cur.b));
    end
  end

  // Drive one cycle of inputs and advance the model at the edge they are sampled.
  task automatic cyc(input bit v, input bit c, input int b00, input int b01, input int b10, input int b11);
    @(negedge clk);
    valid_in = v; clear = c;
    bm00 = 2'(b00); bm01 = 2'(b01); bm10 = 2'(b10); bm11 = 2'(b11);
    @(posedge clk);
    if (c) model_reset();
    else if (v) model_step(b00, b01, b10, b11);
  endtask

  task automatic chk_pm(input string nm, input int e0, input int e1, input int e2, input int e3);
    cmp({nm, " pm0"}, int'(pm0), e0);
    cmp({nm, " pm1"}, int'(pm1), e1);
    cmp({nm, " pm2"}, int'(pm2), e2);
    cmp({nm, " pm3"}, int'(pm3), e3);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; valid_in = 1'b0;
    bm00 = 2'd0; bm01 = 2'd0; bm10 = 2'd0; bm11 = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_pm("reset", 0, 16, 16, 16);
    cmp("reset dec", int'(dec), 0);
    cmp("reset valid_out", int'(valid_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single update from reset metrics, then the pulse must drop.
    cyc(1'b1, 1'b0, 0, 1, 1, 2);
    #1;
    chk_pm("vec1", 0, 17, 2, 17);
    cmp("vec1 dec", int'(dec), 0);
    cmp("vec1 best", int'(best_state), 0);
    cmp("vec1 valid_out", int'(valid_out), 1);
    cyc(1'b0, 1'b0, 0, 0, 0, 0);
    #1;
    cmp("vec1 pulse end", int'(valid_out), 0);

    cyc(1'b0, 1'b1, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 2, 1, 1, 0);
    #1;
    chk_pm("vec2", 2, 17, 0, 17);
    cmp("vec2 dec", int'(dec), 0);
    cmp("vec2 best", int'(best_state), 2);

    // clear outranks valid_in in the same cycle.
    cyc(1'b1, 1'b1, 0, 1, 1, 2);
    #1;
    chk_pm("clear+valid", 0, 16, 16, 16);
    cmp("clear+valid valid_out", int'(valid_out), 0);

    // All-zero codeword stream with a two-cycle gap.
    for (int i = 0; i < 12; i++) begin
      cyc(!(i == 4 || i == 5), 1'b0, 0, $urandom_range(2, 1), $urandom_range(2, 1), $urandom_range(2, 1));
      #1;
      cmp("zero pm0", int'(pm0), 0);
      cmp("zero best", int'(best_state), 0);
    end

    // Maximal-distance stream drives every metric across the threshold.
    cyc(1'b0, 1'b1, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) cyc(1'b1, 1'b0, 2, 2, 2, 2);

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(3, 0) != 0, $urandom_range(31, 0) == 0,
          $urandom_range(2, 0), $urandom_range(2, 0), $urandom_range(2, 0), $urandom_range(2, 0));

    // Asynchronous reset between edges while an update is pending.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, $urandom_range(2, 0), 2, 2, $urandom_range(2, 0));
    @(negedge clk);
    valid_in = 1'b1; bm00 = 2'd1; bm01 = 2'd2; bm10 = 2'd0; bm11 = 2'd1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_pm("async rst", 0, 16, 16, 16);
    cmp("async rst dec", int'(dec), 0);
    cmp("async rst best", int'(best_state), 0);
    cmp("async rst valid_out", int'(valid_out), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_step(1, 2, 0, 1);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, $urandom_range(2, 0), $urandom_range(2, 0), $urandom_range(2, 0), $urandom_range(2, 0));
    cyc(1'b0, 1'b0, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
